// File: rtl/hazard_ctrl_pkg.sv
// ============================================================================
// Module   : hazard_ctrl_pkg
// Purpose  : Shared pipeline-control encodings, counter widths and helpers.
// Revision : 1.0
// ============================================================================
`default_nettype none

package hazard_ctrl_pkg;

    localparam int CYCLE_CNT_W = 32;
    localparam int EVT_CNT_W   = 16;

    typedef logic [1:0] hz_state_t;

    localparam hz_state_t ST_RUN    = 2'd0;
    localparam hz_state_t ST_DRAIN  = 2'd1;
    localparam hz_state_t ST_HALTED = 2'd2;

    // A load into $0 never creates a real dependency, so it never stalls.
    function automatic logic load_use(
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       uses_rs,
        input logic       uses_rt,
        input logic [4:0] rw,
        input logic       mem_to_reg,
        input logic       reg_write
    );
        return mem_to_reg && reg_write && (rw != 5'd0) &&
               ((uses_rs && (rs == rw)) || (uses_rt && (rt == rw)));
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_sat_counter.sv
// ============================================================================
// Module   : sat_counter
// Purpose  : Event counter with synchronous clear; wraps or saturates.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int WIDTH    = 16,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i && !(SATURATE && (&count_q))) begin
            count_d = count_q + C_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline stall/flush/halt control with performance counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic                   id_uses_rs,
    input  logic                   id_uses_rt,
    input  logic                   id_halt,
    input  logic [4:0]             ex_rw,
    input  logic                   ex_MemToReg,
    input  logic                   ex_Regwrite,
    input  logic                   ex_taken,
    input  logic                   wb_halt,
    output logic                   pc_en,
    output logic                   ifid_en,
    output logic                   ifid_flush,
    output logic                   idex_flush,
    output logic                   halted,
    output logic [CYCLE_CNT_W-1:0] cycle_cnt,
    output logic [EVT_CNT_W-1:0]   stall_cnt,
    output logic [EVT_CNT_W-1:0]   flush_cnt
);

    hz_state_t state_q;
    hz_state_t state_d;
    logic      halted_q;
    logic      w_lu;
    logic      w_cycle_en;
    logic      w_stall_en;
    logic      w_flush_en;

    assign w_lu = load_use(id_rs, id_rt, id_uses_rs, id_uses_rt,
                           ex_rw, ex_MemToReg, ex_Regwrite);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= (state_d == ST_HALTED);
        end
    end

    // A halt in ID waits behind a taken branch (wrong path) or a load-use stall.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (!ex_taken && !w_lu && id_halt) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (wb_halt) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
    end

    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        if (!rst) begin
            case (state_q)
                ST_RUN: begin
                    if (ex_taken) begin
                        pc_en      = 1'b1;
                        ifid_en    = 1'b1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (w_lu) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        ifid_flush = 1'b0;
                        idex_flush = 1'b1;
                    end else if (id_halt) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b0;
                    end else begin
                        pc_en      = 1'b1;
                        ifid_en    = 1'b1;
                        ifid_flush = 1'b0;
                        idex_flush = 1'b0;
                    end
                end
                ST_DRAIN: begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b1;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end
                default: begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end
            endcase
        end
    end

    assign halted     = halted_q;
    assign w_cycle_en = (state_q != ST_HALTED);
    assign w_stall_en = (state_q == ST_RUN) && !ex_taken && w_lu;
    assign w_flush_en = (state_q == ST_RUN) && ex_taken;

    sat_counter #(
        .WIDTH    (CYCLE_CNT_W),
        .SATURATE (1'b0)
    ) u_cycle_cnt (
        .clk     (clk),
        .rst     (rst),
        .en_i    (w_cycle_en),
        .count_o (cycle_cnt)
    );

    sat_counter #(
        .WIDTH    (EVT_CNT_W),
        .SATURATE (1'b1)
    ) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .en_i    (w_stall_en),
        .count_o (stall_cnt)
    );

    sat_counter #(
        .WIDTH    (EVT_CNT_W),
        .SATURATE (1'b1)
    ) u_flush_cnt (
        .clk     (clk),
        .rst     (rst),
        .en_i    (w_flush_en),
        .count_o (flush_cnt)
    );

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Directed vector bench for hazard_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rw;
    logic        id_uses_rs, id_uses_rt, id_halt;
    logic        ex_MemToReg, ex_Regwrite, ex_taken, wb_halt;
    logic        pc_en, ifid_en, ifid_flush, idex_flush, halted;
    logic [31:0] cycle_cnt;
    logic [15:0] stall_cnt, flush_cnt;
    logic [3:0]  outs;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rs  (id_uses_rs),
        .id_uses_rt  (id_uses_rt),
        .id_halt     (id_halt),
        .ex_rw       (ex_rw),
        .ex_MemToReg (ex_MemToReg),
        .ex_Regwrite (ex_Regwrite),
        .ex_taken    (ex_taken),
        .wb_halt     (wb_halt),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .ifid_flush  (ifid_flush),
        .idex_flush  (idex_flush),
        .halted      (halted),
        .cycle_cnt   (cycle_cnt),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    assign outs = {pc_en, ifid_en, ifid_flush, idex_flush};

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       halt;
        logic [4:0] rw;
        logic       m2r;
        logic       rwr;
        logic       tk;
        logic [3:0] exp;   // {pc_en, ifid_en, ifid_flush, idex_flush}
        logic [3:0] care;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt,
                                input logic urs, input logic urt, input logic halt,
                                input logic [4:0] rw, input logic m2r, input logic rwr,
                                input logic tk, input logic [3:0] exp,
                                input logic [3:0] care);
        vec_t v;
        v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.halt = halt;
        v.rw = rw; v.m2r = m2r; v.rwr = rwr; v.tk = tk;
        v.exp = exp; v.care = care;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        id_halt = 1'b0; ex_rw = 5'd0; ex_MemToReg = 1'b0; ex_Regwrite = 1'b0;
        ex_taken = 1'b0; wb_halt = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //                rs     rt     urs   urt   halt  rw     m2r   rwr   tk    exp      care
        vecs[0]  = mk(5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 4'b1100, 4'b1111); // idle
        vecs[1]  = mk(5'd3,  5'd0,  1'b1, 1'b0, 1'b0, 5'd3,  1'b1, 1'b1, 1'b0, 4'b0001, 4'b1101); // lw $3, rs
        vecs[2]  = mk(5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 1'b0, 4'b1100, 4'b1111); // load $0
        vecs[3]  = mk(5'd1,  5'd7,  1'b1, 1'b1, 1'b0, 5'd7,  1'b1, 1'b1, 1'b0, 4'b0001, 4'b1101); // lu via rt
        vecs[4]  = mk(5'd1,  5'd7,  1'b1, 1'b0, 1'b0, 5'd7,  1'b1, 1'b1, 1'b0, 4'b1100, 4'b1111); // rt unused
        vecs[5]  = mk(5'd9,  5'd0,  1'b1, 1'b0, 1'b0, 5'd9,  1'b0, 1'b1, 1'b0, 4'b1100, 4'b1111); // ALU writer
        vecs[6]  = mk(5'd9,  5'd0,  1'b1, 1'b0, 1'b0, 5'd9,  1'b1, 1'b0, 1'b0, 4'b1100, 4'b1111); // no regwrite
        vecs[7]  = mk(5'd3,  5'd0,  1'b1, 1'b0, 1'b0, 5'd3,  1'b1, 1'b1, 1'b1, 4'b1111, 4'b1111); // taken + lu
        vecs[8]  = mk(5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 4'b1111, 4'b1111); // taken
        vecs[9]  = mk(5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 1'b1, 4'b1111, 4'b1111); // taken + halt
        vecs[10] = mk(5'd4,  5'd0,  1'b1, 1'b0, 1'b1, 5'd4,  1'b1, 1'b1, 1'b0, 4'b0001, 4'b1101); // lu + halt

        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_outputs", {28'd0, outs}, {28'd0, 4'b0011});
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_cycle", cycle_cnt, 32'd0);
        chk("rst_stall", {16'd0, stall_cnt}, 32'd0);
        chk("rst_flush", {16'd0, flush_cnt}, 32'd0);
        rst = 1'b0;
        #1;
        chk("run_idle", {28'd0, outs}, {28'd0, 4'b1100});

        // Table: every vector stays in RUN; 3 stalls (1,3,10), 3 flushes (7,8,9).
        for (int i = 0; i < 11; i++) begin
            id_rs = vecs[i].rs; id_rt = vecs[i].rt;
            id_uses_rs = vecs[i].urs; id_uses_rt = vecs[i].urt;
            id_halt = vecs[i].halt; ex_rw = vecs[i].rw;
            ex_MemToReg = vecs[i].m2r; ex_Regwrite = vecs[i].rwr;
            ex_taken = vecs[i].tk;
            #1;
            chk($sformatf("vec%0d", i), {28'd0, outs & vecs[i].care},
                {28'd0, vecs[i].exp & vecs[i].care});
            tick();
        end
        clear_inputs();
        #1;
        chk("tbl_stall_cnt", {16'd0, stall_cnt}, 32'd3);
        chk("tbl_flush_cnt", {16'd0, flush_cnt}, 32'd3);
        chk("tbl_cycle_cnt", cycle_cnt, 32'd11);
        chk("tbl_still_run", {28'd0, outs}, {28'd0, 4'b1100});

        // Halt: RUN cycle with id_halt, then drain, wb_halt on the third drain cycle.
        id_halt = 1'b1;
        #1;
        chk("halt_id_pc", {31'd0, pc_en}, 32'd0);
        chk("halt_id_iff", {31'd0, ifid_flush}, 32'd1);
        tick();
        id_halt = 1'b0;
        ex_taken = 1'b1;
        #1;
        chk("drain_pc", {31'd0, pc_en}, 32'd0);
        chk("drain_flushes", {30'd0, ifid_flush, idex_flush}, 32'd3);
        tick();
        ex_taken = 1'b0;
        id_halt = 1'b1;
        tick();
        id_halt = 1'b0;
        wb_halt = 1'b1;
        #1;
        chk("drain_not_halted", {31'd0, halted}, 32'd0);
        tick();
        wb_halt = 1'b0;
        chk("halted_set", {31'd0, halted}, 32'd1);
        chk("halted_outs", {28'd0, outs}, {28'd0, 4'b0011});
        chk("halt_cycle_cnt", cycle_cnt, 32'd15);
        chk("drain_flush_cnt", {16'd0, flush_cnt}, 32'd3);
        for (int i = 0; i < 10; i++) begin
            ex_taken = i[0];
            id_rs = 5'd5; id_uses_rs = 1'b1; ex_rw = 5'd5;
            ex_MemToReg = 1'b1; ex_Regwrite = 1'b1; id_halt = i[1];
            tick();
        end
        clear_inputs();
        #1;
        chk("frozen_cycle", cycle_cnt, 32'd15);
        chk("frozen_stall", {16'd0, stall_cnt}, 32'd3);
        chk("frozen_flush", {16'd0, flush_cnt}, 32'd3);
        chk("frozen_halted", {31'd0, halted}, 32'd1);
        chk("frozen_outs", {28'd0, outs}, {28'd0, 4'b0011});

        // Reset out of HALTED.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_from_halt", {31'd0, halted}, 32'd0);
        chk("rst_from_halt_cyc", cycle_cnt, 32'd0);

        // Reset in DRAIN wins over a simultaneous wb_halt.
        id_halt = 1'b1;
        tick();
        id_halt = 1'b0;
        tick();
        rst = 1'b1;
        wb_halt = 1'b1;
        #1;
        chk("rst_drain_outs", {28'd0, outs}, {28'd0, 4'b0011});
        tick();
        rst = 1'b0;
        wb_halt = 1'b0;
        #1;
        chk("rst_drain_run", {28'd0, outs}, {28'd0, 4'b1100});
        chk("rst_drain_halted", {31'd0, halted}, 32'd0);
        chk("rst_drain_cycle", cycle_cnt, 32'd0);
        chk("rst_drain_stall", {16'd0, stall_cnt}, 32'd0);
        chk("rst_drain_flush", {16'd0, flush_cnt}, 32'd0);

        // Stall saturation.
        id_rs = 5'd6; id_uses_rs = 1'b1; ex_rw = 5'd6;
        ex_MemToReg = 1'b1; ex_Regwrite = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        chk("stall_full", {16'd0, stall_cnt}, 32'h0000_FFFF);
        tick();
        chk("stall_sat", {16'd0, stall_cnt}, 32'h0000_FFFF);
        chk("sat_cycle", cycle_cnt, 32'd65536);
        chk("sat_outs", {28'd0, outs & 4'b1101}, {28'd0, 4'b0001});
        clear_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
